// File: rtl/pre_adder_arbiter_if.sv
// ============================================================================
// Module      : pre_adder_arbiter_if
// Description : Requester, result and handshake bundle for pre_adder_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pre_adder_arbiter_if;
   logic        r0_valid;
   logic        r0_ready;
   logic        r0_mode;
   logic [36:0] r0_in1;
   logic [36:0] r0_in2;
   logic        r1_valid;
   logic        r1_ready;
   logic        r1_mode;
   logic [36:0] r1_in1;
   logic [36:0] r1_in2;
   logic        out_valid;
   logic        out_ready;
   logic [37:0] out_data;
   logic        out_id;
   logic        out_mode;

   modport slave (
      input  r0_valid, r0_mode, r0_in1, r0_in2,
      input  r1_valid, r1_mode, r1_in1, r1_in2,
      input  out_ready,
      output r0_ready, r1_ready,
      output out_valid, out_data, out_id, out_mode
   );

   modport master (
      output r0_valid, r0_mode, r0_in1, r0_in2,
      output r1_valid, r1_mode, r1_in1, r1_in2,
      output out_ready,
      input  r0_ready, r1_ready,
      input  out_valid, out_data, out_id, out_mode
   );
endinterface

`default_nettype wire

// File: rtl/pre_adder_arbiter.sv
// ============================================================================
// Module      : pre_adder_arbiter
// Description : Two-requester round-robin front end to one shared, two-stage,
//               mode-switchable (dual 19-bit / single 27-bit) pre-adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pre_adder_arbiter (
   input  wire logic           clk,
   input  wire logic           rst_n,
   pre_adder_arbiter_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_SWITCH = 1'b1
   } state_t;

   state_t      r_state;
   logic        r_ptr;
   logic        r_cur_mode;
   logic        r_lat_id;
   logic        r_lat_mode;
   logic        r_prio_vld;

   logic        r_s1_vld;
   logic        r_s1_mode;
   logic        r_s1_id;
   logic [36:0] r_s1_in1;
   logic [36:0] r_s1_in2;

   logic        r_s2_vld;
   logic        r_s2_mode;
   logic        r_s2_id;
   logic [37:0] r_s2_data;

   logic        w_s2_load;
   logic        w_s1_free;
   logic        w_any;
   logic        w_lat_valid;
   logic        w_win_id;
   logic        w_win_mode;
   logic        w_grant;
   logic        w_need_switch;
   logic [18:0] w_sum_lo;
   logic [18:0] w_sum_hi;
   logic [27:0] w_sum_wide;
   logic [37:0] w_sum;

   always_comb begin
      w_s2_load   = !r_s2_vld || bus.out_ready;
      w_s1_free   = !r_s1_vld || w_s2_load;
      w_any       = bus.r0_valid || bus.r1_valid;
      w_lat_valid = r_lat_id ? bus.r1_valid : bus.r0_valid;

      // A requester that forced a mode switch keeps priority until served or withdrawn.
      if (r_prio_vld && w_lat_valid) begin
         w_win_id = r_lat_id;
      end else if (bus.r0_valid && bus.r1_valid) begin
         w_win_id = r_ptr;
      end else begin
         w_win_id = bus.r1_valid;
      end
      w_win_mode = w_win_id ? bus.r1_mode : bus.r0_mode;

      w_grant       = rst_n && (r_state == ST_RUN) && w_any &&
                      (w_win_mode == r_cur_mode) && w_s1_free;
      w_need_switch = (r_state == ST_RUN) && w_any && (w_win_mode != r_cur_mode);

      bus.r0_ready = w_grant && !w_win_id;
      bus.r1_ready = w_grant &&  w_win_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_ptr      <= 1'b0;
         r_cur_mode <= 1'b0;
         r_lat_id   <= 1'b0;
         r_lat_mode <= 1'b0;
         r_prio_vld <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_need_switch) begin
                  r_state    <= ST_SWITCH;
                  r_lat_id   <= w_win_id;
                  r_lat_mode <= w_win_mode;
                  r_prio_vld <= 1'b0;
               end else begin
                  if (w_grant) begin
                     r_ptr <= ~w_win_id;
                  end
                  if (r_prio_vld && (w_grant || !w_lat_valid)) begin
                     r_prio_vld <= 1'b0;
                  end
               end
            end
            ST_SWITCH: begin
               r_cur_mode <= r_lat_mode;
               r_prio_vld <= 1'b1;
               r_state    <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_mode <= 1'b0;
         r_s1_id   <= 1'b0;
         r_s1_in1  <= '0;
         r_s1_in2  <= '0;
      end else if (w_s1_free) begin
         r_s1_vld <= w_grant;
         if (w_grant) begin
            r_s1_mode <= w_win_mode;
            r_s1_id   <= w_win_id;
            r_s1_in1  <= w_win_id ? bus.r1_in1 : bus.r0_in1;
            r_s1_in2  <= w_win_id ? bus.r1_in2 : bus.r0_in2;
         end
      end
   end

   always_comb begin
      w_sum_lo   = r_s1_in1[18:0] + {1'b0, r_s1_in1[36:19]};
      w_sum_hi   = r_s1_in2[18:0] + {1'b0, r_s1_in2[36:19]};
      w_sum_wide = {1'b0, r_s1_in1[26:0]} + {2'b00, r_s1_in2[15:0], r_s1_in1[36:27]};
      w_sum      = r_s1_mode ? {10'd0, w_sum_wide} : {w_sum_hi, w_sum_lo};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld  <= 1'b0;
         r_s2_mode <= 1'b0;
         r_s2_id   <= 1'b0;
         r_s2_data <= '0;
      end else if (w_s2_load) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_mode <= r_s1_mode;
            r_s2_id   <= r_s1_id;
            r_s2_data <= w_sum;
         end
      end
   end

   assign bus.out_valid = r_s2_vld;
   assign bus.out_data  = r_s2_data;
   assign bus.out_id    = r_s2_id;
   assign bus.out_mode  = r_s2_mode;

endmodule

`default_nettype wire

// File: tb/tb_pre_adder_arbiter.sv
// ============================================================================
// Module      : tb_pre_adder_arbiter
// Description : Directed self-checking bench for pre_adder_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pre_adder_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   pre_adder_arbiter_if bus ();

   pre_adder_arbiter u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [37:0] act, input logic [37:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_reqs();
      bus.r0_valid = 1'b0; bus.r0_mode = 1'b0; bus.r0_in1 = '0; bus.r0_in2 = '0;
      bus.r1_valid = 1'b0; bus.r1_mode = 1'b0; bus.r1_in1 = '0; bus.r1_in2 = '0;
   endtask

   // Expected tables for the alternating and mode-ping-pong scenarios
   logic       alt_r0r [8] = '{0, 0, 1, 0, 1, 0, 0, 0};
   logic       alt_r1r [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
   logic       alt_ov  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   logic       alt_id  [8] = '{0, 0, 0, 0, 0, 1, 0, 1};
   logic       pp_r0r  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
   logic       pp_r1r  [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
   logic       pp_ov   [8] = '{0, 0, 0, 0, 1, 0, 0, 1};

   int n_acc;
   int n_out;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      idle_reqs();
      bus.out_ready = 1'b1;
      bus.r0_valid  = 1'b1;
      repeat (3) step();
      chk("rst_out_valid", 38'(bus.out_valid), 38'd0);
      chk("rst_out_data",  bus.out_data,       38'd0);
      chk("rst_out_id",    38'(bus.out_id),    38'd0);
      chk("rst_out_mode",  38'(bus.out_mode),  38'd0);
      chk("rst_r0_ready",  38'(bus.r0_ready),  38'd0);
      bus.r0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Single mode-0 op from r0
      bus.r0_valid = 1'b1; bus.r0_mode = 1'b0;
      bus.r0_in1 = {18'd5, 19'd7}; bus.r0_in2 = {18'd1, 19'h7FFFF};
      #1;
      chk("t1_r0_ready", 38'(bus.r0_ready), 38'd1);
      chk("t1_r1_ready", 38'(bus.r1_ready), 38'd0);
      step();
      bus.r0_valid = 1'b0;
      chk("t1_latency_n1", 38'(bus.out_valid), 38'd0);
      step();
      chk("t1_out_valid", 38'(bus.out_valid), 38'd1);
      chk("t1_out_data",  bus.out_data,       38'd12);
      chk("t1_out_id",    38'(bus.out_id),    38'd0);
      chk("t1_out_mode",  38'(bus.out_mode),  38'd0);

      // Mode-1 op from r1 forces a switch
      step();
      bus.r1_valid = 1'b1; bus.r1_mode = 1'b1;
      bus.r1_in1 = {10'd1, 27'h7FFFFFF}; bus.r1_in2 = 37'h1FFFFF0000;
      #1;
      chk("t2_run_noready", 38'(bus.r1_ready), 38'd0);
      step();
      chk("t2_switch_noready", 38'(bus.r1_ready), 38'd0);
      step();
      chk("t2_grant", 38'(bus.r1_ready), 38'd1);
      step();
      bus.r1_valid = 1'b0;
      step();
      chk("t2_out_valid", 38'(bus.out_valid), 38'd1);
      chk("t2_out_data",  bus.out_data,       38'h8000000);
      chk("t2_out_mode",  38'(bus.out_mode),  38'd1);
      chk("t2_out_id",    38'(bus.out_id),    38'd1);

      // Both mode 0 continuously: one switch back, then strict alternation
      for (int k = 0; k < 8; k++) begin
         step();
         bus.r0_valid = (k < 6); bus.r0_mode = 1'b0;
         bus.r0_in1 = {18'd1, 19'd2}; bus.r0_in2 = {18'd3, 19'd4};
         bus.r1_valid = (k < 6); bus.r1_mode = 1'b0;
         bus.r1_in1 = {18'd10, 19'd20}; bus.r1_in2 = {18'd100, 19'd200};
         #1;
         chk("t3_r0_ready", 38'(bus.r0_ready), 38'(alt_r0r[k]));
         chk("t3_r1_ready", 38'(bus.r1_ready), 38'(alt_r1r[k]));
         chk("t3_out_valid", 38'(bus.out_valid), 38'(alt_ov[k]));
         if (alt_ov[k]) begin
            chk("t3_out_id", 38'(bus.out_id), 38'(alt_id[k]));
            chk("t3_out_data", bus.out_data,
                alt_id[k] ? {19'd300, 19'd30} : {19'd7, 19'd3});
         end
      end
      idle_reqs();

      // r0 streaming under 5 cycles of backpressure
      n_acc = 0;
      n_out = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         bus.out_ready = (c >= 5);
         bus.r0_valid  = (c < 10);
         bus.r0_mode   = 1'b0;
         bus.r0_in1    = {18'd0, 19'(n_acc + 1)};
         bus.r0_in2    = '0;
         #1;
         if (c >= 2 && c <= 4) begin
            chk("t4_stall_valid", 38'(bus.out_valid), 38'd1);
            chk("t4_stall_hold",  bus.out_data,       38'd1);
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("t4_stream_data", bus.out_data, 38'(n_out + 1));
            n_out++;
         end
         if (bus.r0_valid && bus.r0_ready) n_acc++;
         if (c == 4) chk("t4_acc_during_stall", 38'(n_acc), 38'd2);
      end
      chk("t4_total_acc", 38'(n_acc), 38'd7);
      chk("t4_total_out", 38'(n_out), 38'd7);
      idle_reqs();

      // r0 mode 0 vs r1 mode 1 with pointer at r1
      for (int c = 0; c < 8; c++) begin
         step();
         bus.r0_valid = (c <= 5); bus.r0_mode = 1'b0;
         bus.r0_in1 = {18'd9, 19'd1}; bus.r0_in2 = '0;
         bus.r1_valid = (c <= 2); bus.r1_mode = 1'b1;
         bus.r1_in1 = {10'd3, 27'd5}; bus.r1_in2 = 37'h1FFFFF0002;
         #1;
         chk("t5_r0_ready", 38'(bus.r0_ready), 38'(pp_r0r[c]));
         chk("t5_r1_ready", 38'(bus.r1_ready), 38'(pp_r1r[c]));
         chk("t5_out_valid", 38'(bus.out_valid), 38'(pp_ov[c]));
         if (c == 4) begin
            chk("t5_r1_data", bus.out_data,      38'd2056);
            chk("t5_r1_id",   38'(bus.out_id),   38'd1);
            chk("t5_r1_mode", 38'(bus.out_mode), 38'd1);
         end
         if (c == 7) begin
            chk("t5_r0_data", bus.out_data,      38'd10);
            chk("t5_r0_id",   38'(bus.out_id),   38'd0);
            chk("t5_r0_mode", 38'(bus.out_mode), 38'd0);
         end
      end
      idle_reqs();

      // Reset with S1 and S2 full
      step();
      bus.out_ready = 1'b0;
      bus.r0_valid = 1'b1; bus.r0_mode = 1'b0;
      bus.r0_in1 = {18'd4, 19'd4}; bus.r0_in2 = '0;
      step();
      step();
      chk("t6_pre_full", 38'(bus.out_valid), 38'd1);
      chk("t6_pre_stall", 38'(bus.r0_ready), 38'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", 38'(bus.out_valid), 38'd0);
      chk("t6_rst_out_data",  bus.out_data,       38'd0);
      chk("t6_rst_r0_ready",  38'(bus.r0_ready),  38'd0);
      idle_reqs();
      bus.out_ready = 1'b1;
      repeat (2) step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("t6_no_stale", 38'(bus.out_valid), 38'd0);
      end

      // Grant on first edge after reset release; pointer back at r0
      rst_n = 1'b0;
      step();
      @(negedge clk);
      rst_n = 1'b1;
      bus.r0_valid = 1'b1; bus.r0_in1 = {18'd2, 19'd3}; bus.r0_in2 = '0;
      bus.r1_valid = 1'b1; bus.r1_in1 = {18'd8, 19'd8}; bus.r1_in2 = '0;
      #1;
      chk("t7_first_r0_ready", 38'(bus.r0_ready), 38'd1);
      chk("t7_first_r1_ready", 38'(bus.r1_ready), 38'd0);
      step();
      idle_reqs();
      chk("t7_out_n1", 38'(bus.out_valid), 38'd0);
      step();
      chk("t7_out_valid", 38'(bus.out_valid), 38'd1);
      chk("t7_out_data",  bus.out_data,       38'd5);
      chk("t7_out_id",    38'(bus.out_id),    38'd0);

      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pre_adder_arbiter.md
PRE_ADDER_ARBITER -- requirements
Module: pre_adder_arbiter

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 r0_valid, r1_valid  input  1 each  requester operation offered.
REQ-005 r0_ready, r1_ready  output  1 each  requester operation accepted this cycle when valid also high.
REQ-006 r0_mode, r1_mode  input  1 each  0 = dual 19-bit add, 1 = single 27-bit add.
REQ-007 r0_in1, r0_in2, r1_in1, r1_in2  input  37 each  packed operands.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_data  output  38  result.
REQ-011 out_id  output  1  requester that issued the result (0 or 1).
REQ-012 out_mode  output  1  mode used for the result.

Function
REQ-013 Arithmetic, mode 0: out_data[18:0] = (in1[18:0] + in1[36:19]) mod 2^19; out_data[37:19] = (in2[18:0] + in2[36:19]) mod 2^19; no carry between halves.
REQ-014 Arithmetic, mode 1: out_data = zero-extend(in1[26:0] + {in2[15:0], in1[36:27]}), full 28-bit sum with no truncation; in1 and in2 bits outside these fields are ignored.
REQ-015 The block owns one shared pre-adder datapath; at most one operation enters it per cycle.
REQ-016 Pipeline: stage S1 registers the selected operands, mode and id; stage S2 registers the sum, mode and id; S2 drives out_*.
REQ-017 Latency: an operation handshaken in cycle N shows out_valid=1 in cycle N+2 when there is no stall.
REQ-018 Throughput: one operation per cycle sustained while mode is unchanged and out_ready=1.
REQ-019 Backpressure: out_valid and out_* stay stable while out_ready=0; S2 loads only when S2 is empty or being drained that cycle.
REQ-020 S1 advances only when S2 can load; the grant is allowed only when S1 is empty or advancing.
REQ-021 Arbitration: round-robin using a 1-bit priority pointer. When both are valid, the pointer's requester wins; when only one is valid, that requester wins.
REQ-022 After a completed grant to rX, the pointer moves to the other requester. The pointer does not move without a completed grant.
REQ-023 At most one of r0_ready/r1_ready is high per cycle, and only toward the current winner.
REQ-024 Each ready is low whenever the corresponding valid is low.
REQ-025 A cur_mode register holds the configured datapath mode.
REQ-026 FSM states: RUN and SWITCH.
REQ-027 RUN: if the winner's mode equals cur_mode, grant per REQ-020. If it differs, issue no grant, latch the winner id, and go to SWITCH.
REQ-028 SWITCH: lasts exactly one cycle with both readys low. It sets cur_mode to the latched winner's mode and returns to RUN.
REQ-029 On the RUN cycle after SWITCH, the latched winner has priority regardless of the pointer, if it is still valid. If it has dropped valid, normal arbitration applies.
REQ-030 Operations already in S1/S2 complete unaffected by a mode switch.
REQ-031 A requester dropping valid without a handshake is legal and causes no state change.

Reset
REQ-032 While rst_n=0: out_valid=0, out_data=0, out_id=0, out_mode=0, r0_ready=r1_ready=0, S1/S2 empty, pointer=0 (r0 first), cur_mode=0, FSM=RUN, latched winner cleared.
REQ-033 Reset asserted mid-operation discards all in-flight operations; no partial result is ever presented after rst_n rises.
REQ-034 The first grant is possible in the first clock edge after rst_n deasserts.

Verification
REQ-035 r0 mode 0, in1={18'd5,19'd7}, in2={18'd1,19'h7FFFF}, out_ready=1 -> 2 cycles later out_data[18:0]=12, out_data[37:19]=0, out_id=0.
REQ-036 r1 mode 1, in1[26:0]=27'h7FFFFFF, in1[36:27]=1, in2[15:0]=0 -> SWITCH cycle, then grant, out_data=38'h8000000, out_mode=1.
REQ-037 Both requesters valid continuously, mode 0 -> grants alternate r0,r1,r0,r1; out_id alternates with one result per cycle.
REQ-038 Hold out_ready=0 for 5 cycles with r0 streaming -> at most 2 operations accepted; out_data stable; no loss or duplication after release.
REQ-039 r0 mode 0 and r1 mode 1 both valid, pointer=1 -> SWITCH, r1 granted next, then SWITCH back, then r0 granted.
REQ-040 Assert rst_n=0 with S1 and S2 full -> all outputs go to reset values immediately; no result appears after release.
